// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store path.
// Data wins ties unless fetch has waited STARVE_MAX cycles; TIMEOUT bounds a hung memory.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;
  logic tmo_hit;

  // A requester whose ready is high this cycle is still holding req while it
  // drops it; treating it as ineligible prevents issuing the same request twice.
  always_comb begin
    i_elig  = i_req && !i_ready;
    d_elig  = d_req && !d_ready;
    grant_i = (state == IDLE) && i_elig && (!d_elig || (starve_cnt >= STARVE_LIM));
    grant_d = (state == IDLE) && d_elig && !grant_i;
    tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      i_ready    <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      if (grant_i) begin
        starve_cnt <= '0;
      end else if (i_req && (state != BUSY_I) && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_i) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= '1;
            tmo_cnt <= '0;
            state   <= BUSY_I;
          end else if (grant_d) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
            tmo_cnt <= '0;
            state   <= BUSY_D;
          end
        end

        BUSY_I, BUSY_D: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= IDLE;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= m_rdata;
            end else begin
              d_ready <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= m_we ? '0 : m_rdata;
            end
          end else if (tmo_hit) begin
            m_req <= 1'b0;
            state <= IDLE;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= '0;
            end else begin
              d_ready <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single data transactions plus
// hand-written sequences for arbitration, starvation, timeout and reset.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  // Memory model: auto mode acks one cycle after m_req, manual mode is driven by the test.
  logic          mem_auto  = 1'b0;
  logic          auto_ack  = 1'b0;
  logic          man_ack   = 1'b0;
  logic [DW-1:0] mem_data  = '0;
  logic [DW-1:0] man_rdata = '0;

  assign m_ack   = mem_auto ? auto_ack : man_ack;
  assign m_rdata = mem_auto ? mem_data : man_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX),
    .TIMEOUT   (TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_ready(i_ready),
    .i_rdata(i_rdata),
    .i_err  (i_err),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_be   (d_be),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .d_err  (d_err),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_be   (m_be),
    .m_ack  (m_ack),
    .m_rdata(m_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counts, grant log and command stability while m_req is high.
  int            cyc       = 0;
  int            i_pulses  = 0;
  int            d_pulses  = 0;
  logic          prev_mreq = 1'b0;
  logic [68:0]   hold_cmd  = '0;
  logic [AW-1:0] gaddr[$];
  int            gcyc[$];

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    auto_ack = m_req;
    if (i_ready) i_pulses++;
    if (d_ready) d_pulses++;
    if (m_req && !prev_mreq) begin
      gaddr.push_back(m_addr);
      gcyc.push_back(cyc);
      hold_cmd = {m_we, m_addr, m_wdata, m_be};
    end else if (m_req) begin
      check("m_cmd_stable", {m_we, m_addr, m_wdata, m_be}, hold_cmd);
    end
    prev_mreq = m_req;
  end

  task automatic wait_ready(input bit fetch, input int maxc, output int lat);
    lat = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (fetch ? i_ready : d_ready) begin
        lat = k;
        break;
      end
    end
    check(fetch ? "i_ready_seen" : "d_ready_seen", lat != 0, 1);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] mem;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  int   lat;
  int   dp0;
  int   ip0;
  int   n;
  bit   got;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'b0011, 32'h1234_5678, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h8000_0001, 32'h8000_0001};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_7FF0, 32'h0000_0000, 4'b0000, 32'h0000_0001, 32'h0000_0001};

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (2) @(negedge clk);
    check("rst_m_req",   m_req,   0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_errs",    {i_err, d_err}, 0);
    check("rst_m_cmd",   {m_we, m_addr, m_wdata, m_be}, 0);
    check("rst_rdata",   {i_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: single data transactions against an immediately-acking memory.
    mem_auto = 1'b1;
    for (int v = 0; v < 5; v++) begin
      d_we     = vecs[v].we;
      d_addr   = vecs[v].addr;
      d_wdata  = vecs[v].wdata;
      d_be     = vecs[v].be;
      mem_data = vecs[v].mem;
      d_req    = 1'b1;
      dp0      = d_pulses;
      wait_ready(1'b0, 10, lat);
      check("vec_latency", lat, 2);
      check("vec_d_rdata", d_rdata, vecs[v].exp_rdata);
      check("vec_d_err",   d_err, 0);
      check("vec_m_we",    hold_cmd[68], vecs[v].we);
      check("vec_m_addr",  hold_cmd[67:36], vecs[v].addr);
      if (vecs[v].we) begin
        check("vec_m_wdata", hold_cmd[35:4], vecs[v].wdata);
        check("vec_m_be",    hold_cmd[3:0], vecs[v].be);
      end
      d_req = 1'b0;
      @(negedge clk);
      check("vec_ready_one_cycle", d_ready, 0);
      check("vec_pulse_count", d_pulses - dp0, 1);
    end
    check("no_fetch_ready", i_pulses, 0);

    // Simultaneous requests: data first, fetch granted on the ready cycle.
    gaddr.delete();
    gcyc.delete();
    i_addr = 32'h0; d_addr = 32'h200; d_we = 1'b0; mem_data = 32'h1357_9BDF;
    i_req = 1'b1; d_req = 1'b1;
    wait_ready(1'b0, 10, lat);
    d_req = 1'b0;
    wait_ready(1'b1, 10, lat);
    check("sim_i_latency", lat, 2);
    i_req = 1'b0;
    check("sim_i_rdata", i_rdata, 32'h1357_9BDF);
    check("sim_i_err", i_err, 0);
    check("sim_grant_count", gaddr.size(), 2);
    if (gaddr.size() == 2) begin
      check("sim_first_addr",  gaddr[0], 32'h200);
      check("sim_second_addr", gaddr[1], 32'h0);
      check("sim_no_bubble",   gcyc[1] - gcyc[0], 2);
    end
    @(negedge clk);

    // Starvation with fetch held: counter saturates during a slow data access.
    mem_auto = 1'b0; man_ack = 1'b0;
    d_addr = 32'h400; d_req = 1'b1;
    @(negedge clk);
    i_addr = 32'h444; i_req = 1'b1;
    repeat (6) @(negedge clk);
    check("stv_saturated", dut.starve_cnt, SMAX);
    check("stv_data_held", {m_req, m_addr}, {1'b1, 32'h400});
    man_rdata = 32'h0000_4444; man_ack = 1'b1;
    wait_ready(1'b0, 4, lat);
    man_ack = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("stv_fetch_granted", {m_req, m_addr}, {1'b1, 32'h444});
    check("stv_counter_cleared", dut.starve_cnt, 0);
    man_rdata = 32'h0000_5555; man_ack = 1'b1;
    wait_ready(1'b1, 4, lat);
    man_ack = 1'b0; i_req = 1'b0;
    check("stv_i_rdata", i_rdata, 32'h0000_5555);

    // Starved fetch re-requested together with data: fetch wins the tie.
    d_addr = 32'h500; d_req = 1'b1;
    @(negedge clk);
    i_addr = 32'h600; i_req = 1'b1;
    repeat (5) @(negedge clk);
    i_req = 1'b0; man_rdata = 32'h0000_0500; man_ack = 1'b1;
    wait_ready(1'b0, 4, lat);
    man_ack = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("tie_idle", m_req, 0);
    d_addr = 32'h504; d_req = 1'b1; i_req = 1'b1;
    @(negedge clk);
    check("tie_fetch_wins", {m_req, m_addr}, {1'b1, 32'h600});
    check("tie_counter_cleared", dut.starve_cnt, 0);
    mem_data = 32'h6060_6060; mem_auto = 1'b1;
    wait_ready(1'b1, 4, lat);
    i_req = 1'b0;
    check("tie_i_rdata", i_rdata, 32'h6060_6060);
    wait_ready(1'b0, 4, lat);
    d_req = 1'b0;
    check("tie_data_after", hold_cmd[67:36], 32'h504);
    check("tie_d_rdata", d_rdata, 32'h6060_6060);
    @(negedge clk);

    // Timeout on fetch, then a late ack must be ignored.
    mem_auto = 1'b0; man_ack = 1'b0;
    i_addr = 32'h700; i_req = 1'b1;
    n = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (i_ready) got = 1'b1;
      else if (m_req) n++;
    end
    check("tmo_ready_seen", got, 1);
    check("tmo_busy_cycles", n, TMO);
    check("tmo_i_err", i_err, 1);
    check("tmo_i_rdata", i_rdata, 0);
    check("tmo_m_req_drop", m_req, 0);
    check("tmo_addr", hold_cmd[67:36], 32'h700);
    i_req = 1'b0;
    ip0 = i_pulses;
    man_rdata = 32'hBADB_AD00; man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    check("late_ack_no_ready", i_pulses - ip0, 0);
    check("late_ack_no_mreq", m_req, 0);
    check("late_ack_held", {i_err, i_rdata}, {1'b1, 32'h0});

    // Reset during a data transaction.
    d_addr = 32'h300; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rmid_busy", {m_req, m_addr}, {1'b1, 32'h300});
    dp0 = d_pulses;
    rst_n = 1'b0;
    #1;
    check("rmid_async_m_req", m_req, 0);
    check("rmid_err_cleared", {i_err, d_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (m_req) got = 1'b1;
    end
    check("rmid_regrant", {got, m_addr}, {1'b1, 32'h300});
    check("rmid_no_d_ready", d_pulses - dp0, 0);
    mem_data = 32'h0F0F_1234; mem_auto = 1'b1;
    wait_ready(1'b0, 6, lat);
    d_req = 1'b0;
    check("rmid_d_rdata", d_rdata, 32'h0F0F_1234);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1);
  end

endmodule
